bellek_asamasi: RTL

- Memory stage that sits downstream of the execute stage and consumes its memory-side outputs: address, store data, load/store type, read/write enables, plus the write-back fields.
- Runs a request/response handshake with the data memory/cache, aligns and extends load data, and registers the results for the write-back stage.
- Holds the pipeline via bellek_stall_o while a transaction is in flight.

---
 rtl/bellek_asamasi.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bellek_asamasi.sv
// bellek_asamasi: memory stage between execute and write-back.
//
// Takes the memory-side outputs of execute (address, store data, access type,
// load/store enables) and the write-back fields. It drives a valid/ready
// request channel and a valid-only response channel toward the data memory.
// Load data is aligned and extended, and the write-back fields are registered
// for the next stage.
//
// Request handshake: veri_istek_gecerli_o stays high, with address, data, mask
// and write direction held constant, until the cycle in which
// veri_istek_hazir_i is also high. That cycle transfers the request. The
// response channel has no back-pressure. A load completes in the cycle in
// which veri_yanit_gecerli_i is high.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   durdur_i                     global pipeline freeze
//   bellek_adresi_i/_veri_i      byte address and store data from execute
//   load_save_buyrugu_i          000 B, 001 H, 010 W, 100 BU, 101 HU
//   bellekten_oku_i/bellege_yaz_i load / store (load wins if both are set)
//   hedef_yazmac_verisi_i, yazmaca_yaz_i, hedef_yazmaci_i  write-back fields
//   veri_istek_* / veri_adres_o / veri_yaz_* / veri_maske_o  request channel
//   veri_yanit_gecerli_i, veri_oku_veri_i                    response channel
//   bellek_stall_o               holds the upstream pipeline
//   hata_o                       one-cycle pulse on misalignment or timeout
//   hedef_yazmac_verisi_o, yazmaca_yaz_o, hedef_yazmaci_o    write-back outputs
//
// The FSM state is held in durum_q, a typed enum, so hierarchical checkers can
// observe it.
module bellek_asamasi #(
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        durdur_i,
    input  logic [31:0] bellek_adresi_i,
    input  logic [31:0] bellek_veri_i,
    input  logic [2:0]  load_save_buyrugu_i,
    input  logic        bellekten_oku_i,
    input  logic        bellege_yaz_i,
    input  logic [31:0] hedef_yazmac_verisi_i,
    input  logic        yazmaca_yaz_i,
    input  logic [4:0]  hedef_yazmaci_i,
    output logic        veri_istek_gecerli_o,
    input  logic        veri_istek_hazir_i,
    output logic [31:0] veri_adres_o,
    output logic        veri_yaz_o,
    output logic [31:0] veri_yaz_veri_o,
    output logic [3:0]  veri_maske_o,
    input  logic        veri_yanit_gecerli_i,
    input  logic [31:0] veri_oku_veri_i,
    output logic        bellek_stall_o,
    output logic        hata_o,
    output logic [31:0] hedef_yazmac_verisi_o,
    output logic        yazmaca_yaz_o,
    output logic [4:0]  hedef_yazmaci_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2,
        BITTI = 2'd3
    } durum_t;

    localparam int SAYAC_W = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI + 1) : 1;
    localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);

    durum_t              durum_q, durum_d;
    logic [SAYAC_W-1:0]  sayac_q, sayac_d;
    logic                hata_d;

    // Transaction registers, captured when a memory operation leaves BOSTA.
    logic [31:0] adres_q;
    logic [2:0]  tip_q;
    logic [31:0] yaz_veri_q;
    logic [3:0]  maske_q;
    logic        yukle_q;
    logic        yaz_q;
    logic        yazmac_yaz_q;
    logic [4:0]  yazmac_q;
    logic [31:0] okunan_q;
    logic        asim_q;

    // Decode of the incoming operation.
    logic        islem;
    logic        hizasiz;
    logic [3:0]  maske_hesap;
    logic [31:0] veri_hesap;
    logic [31:0] hizali_veri;

    // Control strobes from the next-state logic.
    logic basla;       // memory operation accepted in BOSTA
    logic gec_bosta;   // non-memory (or misaligned) op passes straight through
    logic gec_bitti;   // memory op retires to the output registers
    logic asim_olay;   // timeout fired this cycle

    assign islem = bellekten_oku_i | bellege_yaz_i;

    // Size is taken from the low two bits: 00 byte, 01 half, 1x word.
    always_comb begin
        hizasiz = 1'b0;
        if (islem) begin
            unique case (load_save_buyrugu_i[1:0])
                2'b00:   hizasiz = 1'b0;
                2'b01:   hizasiz = bellek_adresi_i[0];
                default: hizasiz = (bellek_adresi_i[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        maske_hesap = 4'b1111;
        veri_hesap  = bellek_veri_i;
        unique case (load_save_buyrugu_i[1:0])
            2'b00: begin
                maske_hesap = 4'b0001 << bellek_adresi_i[1:0];
                veri_hesap  = {4{bellek_veri_i[7:0]}};
            end
            2'b01: begin
                maske_hesap = 4'b0011 << {bellek_adresi_i[1], 1'b0};
                veri_hesap  = {2{bellek_veri_i[15:0]}};
            end
            default: begin
                maske_hesap = 4'b1111;
                veri_hesap  = bellek_veri_i;
            end
        endcase
    end

    // Load alignment uses the latched address and type, not the live inputs.
    always_comb begin
        logic [7:0]  bayt;
        logic [15:0] yarim;
        bayt        = 8'h00;
        yarim       = adres_q[1] ? veri_oku_veri_i[31:16] : veri_oku_veri_i[15:0];
        hizali_veri = veri_oku_veri_i;
        unique case (adres_q[1:0])
            2'b00: bayt = veri_oku_veri_i[7:0];
            2'b01: bayt = veri_oku_veri_i[15:8];
            2'b10: bayt = veri_oku_veri_i[23:16];
            2'b11: bayt = veri_oku_veri_i[31:24];
        endcase
        unique case (tip_q[1:0])
            2'b00:   hizali_veri = tip_q[2] ? {24'h0, bayt}  : {{24{bayt[7]}}, bayt};
            2'b01:   hizali_veri = tip_q[2] ? {16'h0, yarim} : {{16{yarim[15]}}, yarim};
            default: hizali_veri = veri_oku_veri_i;
        endcase
    end

    // Next-state logic. ISTEK and YANIT ignore durdur_i so that a handshake
    // already started with the memory always completes.
    always_comb begin
        durum_d   = durum_q;
        sayac_d   = '0;
        hata_d    = 1'b0;
        basla     = 1'b0;
        gec_bosta = 1'b0;
        gec_bitti = 1'b0;
        asim_olay = 1'b0;
        unique case (durum_q)
            BOSTA: begin
                if (!durdur_i) begin
                    if (islem && !hizasiz) begin
                        basla   = 1'b1;
                        durum_d = ISTEK;
                    end else begin
                        gec_bosta = 1'b1;
                        hata_d    = hizasiz;
                    end
                end
            end
            ISTEK: begin
                if (veri_istek_hazir_i) begin
                    durum_d = yukle_q ? YANIT : BITTI;
                end else if (sayac_q == SAYAC_SON) begin
                    durum_d   = BITTI;
                    hata_d    = 1'b1;
                    asim_olay = 1'b1;
                end else begin
                    sayac_d = sayac_q + SAYAC_W'(1);
                end
            end
            YANIT: begin
                if (veri_yanit_gecerli_i) begin
                    durum_d = BITTI;
                end else if (sayac_q == SAYAC_SON) begin
                    durum_d   = BITTI;
                    hata_d    = 1'b1;
                    asim_olay = 1'b1;
                end else begin
                    sayac_d = sayac_q + SAYAC_W'(1);
                end
            end
            BITTI: begin
                if (!durdur_i) begin
                    gec_bitti = 1'b1;
                    durum_d   = BOSTA;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q               <= BOSTA;
            sayac_q               <= '0;
            hata_o                <= 1'b0;
            adres_q               <= '0;
            tip_q                 <= '0;
            yaz_veri_q            <= '0;
            maske_q               <= '0;
            yukle_q               <= 1'b0;
            yaz_q                 <= 1'b0;
            yazmac_yaz_q          <= 1'b0;
            yazmac_q              <= '0;
            okunan_q              <= '0;
            asim_q                <= 1'b0;
            hedef_yazmac_verisi_o <= '0;
            yazmaca_yaz_o         <= 1'b0;
            hedef_yazmaci_o       <= '0;
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            hata_o  <= hata_d;

            if (basla) begin
                adres_q      <= bellek_adresi_i;
                tip_q        <= load_save_buyrugu_i;
                yaz_veri_q   <= veri_hesap;
                maske_q      <= maske_hesap;
                yukle_q      <= bellekten_oku_i;
                yaz_q        <= bellege_yaz_i & !bellekten_oku_i;
                yazmac_yaz_q <= yazmaca_yaz_i;
                yazmac_q     <= hedef_yazmaci_i;
                okunan_q     <= '0;
                asim_q       <= 1'b0;
            end

            if (durum_q == YANIT && veri_yanit_gecerli_i) begin
                okunan_q <= hizali_veri;
            end

            if (asim_olay) begin
                asim_q <= 1'b1;
            end

            if (gec_bosta) begin
                hedef_yazmac_verisi_o <= hedef_yazmac_verisi_i;
                yazmaca_yaz_o         <= yazmaca_yaz_i & !hizasiz;
                hedef_yazmaci_o       <= hedef_yazmaci_i;
            end else if (gec_bitti) begin
                // Stores and timed-out loads never write the register file.
                hedef_yazmac_verisi_o <= okunan_q;
                yazmaca_yaz_o         <= yukle_q & yazmac_yaz_q & !asim_q;
                hedef_yazmaci_o       <= yazmac_q;
            end
        end
    end

    assign veri_istek_gecerli_o = (durum_q == ISTEK);
    assign veri_adres_o         = {adres_q[31:2], 2'b00};
    assign veri_yaz_o           = yaz_q;
    assign veri_yaz_veri_o      = yaz_veri_q;
    assign veri_maske_o         = maske_q;

    // Gated by reset so that the upstream pipeline is released at the moment
    // reset is asserted, even if execute still presents a memory operation.
    assign bellek_stall_o = !rst_i &&
                            ((durum_q == ISTEK) || (durum_q == YANIT) ||
                             (durum_q == BOSTA && islem && !hizasiz));

endmodule
